// File: rtl/mat_feeder.sv
// mat_feeder: skews input vectors into a matrix array, one row per cycle of delay,
// and sequences weight-matrix loads (flush, row injection, load_weight/progress).
module mat_feeder #(
   parameter int WIDTH           = 128,
   parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH)
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_is_weight,
   input  logic [WIDTH-1:0][31:0]   vec_in,
   output logic [WIDTH-1:0][31:0]   data_out,
   output logic                     load_weight,
   output logic [WIDTH_ADDR_SIZE:0] weight_progress,
   output logic                     busy,
   output logic                     weight_underrun
);
   localparam int CW = WIDTH_ADDR_SIZE + 2;
   localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, FLUSH = 2'd2, WLOAD = 2'd3;
   localparam logic [CW-1:0] ONE = CW'(1), K_GAP = CW'(WIDTH - 2), K_ROW = CW'(WIDTH - 1),
                             K_END = CW'(2 * WIDTH);

   logic [1:0]             state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [WIDTH-1:0][31:0] pend_q, pend_d, inj;
   logic                   und_q, und_d, acc;

   // in WLOAD, cnt_q is the row step k; load_weight covers k = 1..2*WIDTH
   assign cmd_ready       = reset_n && (state_q == IDLE || state_q == DATA ||
                            (state_q == WLOAD && cnt_q >= ONE && cnt_q <= K_ROW));
   assign acc             = cmd_valid && cmd_ready;
   assign busy            = state_q != IDLE;
   assign load_weight     = state_q == WLOAD && cnt_q >= ONE;
   assign weight_progress = load_weight ? (WIDTH_ADDR_SIZE + 1)'(cnt_q - ONE) : '0;
   assign weight_underrun = und_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + ONE;
      pend_d  = pend_q;
      und_d   = und_q;
      inj     = '0;
      case (state_q)
         IDLE: begin
            cnt_d = (acc && cmd_is_weight) ? ONE : '0;
            if (acc) begin
               inj     = vec_in;
               state_d = cmd_is_weight ? WLOAD : DATA;
            end
         end
         DATA: begin
            if (acc && cmd_is_weight) begin
               pend_d  = vec_in;
               state_d = FLUSH;
               cnt_d   = '0;
            end else if (acc) begin
               inj   = vec_in;
               cnt_d = '0;
            end else if (cnt_q == K_GAP) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         FLUSH: begin
            if (cnt_q == K_GAP) begin
               state_d = WLOAD;
               cnt_d   = '0;
            end
         end
         default: begin
            inj   = (cnt_q == '0) ? pend_q : acc ? vec_in : '0;
            und_d = und_q || (cmd_ready && !cmd_valid);
            if (cnt_q == K_END) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         und_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         und_q   <= und_d;
      end

   for (genvar r = 0; r < WIDTH; r++) begin : g_row
      logic [r:0][31:0] sh_q;
      always_ff @(posedge clock or negedge reset_n)
         if (!reset_n) sh_q <= '0;
         else begin
            sh_q[0] <= inj[r];
            for (int i = 1; i <= r; i++) sh_q[i] <= sh_q[i-1];
         end
      assign data_out[r] = sh_q[r];
   end
endmodule

// File: tb/tb_mat_feeder.sv
// tb_mat_feeder: randomized and directed stimulus for mat_feeder (WIDTH=4), checked
// every cycle against an event-time reference model of the feeder protocol.
module tb_mat_feeder;
   localparam int W = 4;
   typedef logic [W-1:0][31:0] vec_t;

   logic clock = 1'b0, reset_n = 1'b1, cmd_valid = 1'b0, cmd_is_weight = 1'b0;
   vec_t vec_in = '0, data_out;
   logic cmd_ready, load_weight, busy, weight_underrun;
   logic [2:0] weight_progress;

   int   nvec, nerr, cyc_n, mode, last, fs, w0;
   bit   und;
   vec_t pend;
   vec_t hist[$];

   mat_feeder #(.WIDTH(W)) dut (
      .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_is_weight(cmd_is_weight), .vec_in(vec_in), .data_out(data_out),
      .load_weight(load_weight), .weight_progress(weight_progress), .busy(busy),
      .weight_underrun(weight_underrun)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic vec_t rvec();
      vec_t v;
      for (int r = 0; r < W; r++) v[r] = $urandom;
      return v;
   endfunction

   // mode: 0 idle, 1 data, 2 flush, 3 weight load; w0 = cycle row 0 was injected
   function automatic bit exp_ready();
      return reset_n && (mode < 2 || (mode == 3 && cyc_n - w0 >= 1 && cyc_n - w0 <= W - 1));
   endfunction

   task automatic model_reset();
      mode = 0;
      und  = 0;
      pend = '0;
      hist.delete();
      repeat (W) hist.push_back('0);
   endtask

   task automatic check_outs();
      vec_t e;
      int   k  = cyc_n - w0;
      bit   lw = mode == 3 && k >= 1;
      for (int r = 0; r < W; r++) e[r] = hist[r][r];
      chk("data_out", data_out, e);
      chk("cmd_ready", 128'(cmd_ready), 128'(exp_ready()));
      chk("load_weight", 128'(load_weight), 128'(lw));
      chk("weight_progress", 128'(weight_progress), 128'(lw ? k - 1 : 0));
      chk("busy", 128'(busy), 128'(mode != 0));
      chk("weight_underrun", 128'(weight_underrun), 128'(und));
   endtask

   task automatic model_edge(input bit v);
      bit   acc = v && exp_ready();
      vec_t inj = '0;
      int   k   = cyc_n - w0;
      case (mode)
         0: if (acc) begin
               inj  = vec_in;
               mode = cmd_is_weight ? 3 : 1;
               w0   = cyc_n;
               last = cyc_n;
            end
         1: if (acc && cmd_is_weight) begin
               pend = vec_in;
               mode = 2;
               fs   = cyc_n;
            end else if (acc) begin
               inj  = vec_in;
               last = cyc_n;
            end else if (cyc_n - last == W - 1) mode = 0;
         2: if (cyc_n - fs == W - 1) begin
               mode = 3;
               w0   = cyc_n + 1;
            end
         default: begin
            if (k == 0) inj = pend;
            else if (acc) inj = vec_in;
            else if (k < W) und = 1;
            if (k == 2 * W) mode = 0;
         end
      endcase
      hist.push_front(inj);
      void'(hist.pop_back());
   endtask

   task automatic step(input bit v, input bit w, input vec_t d);
      @(negedge clock);
      check_outs();
      cmd_valid     = v;
      cmd_is_weight = w;
      vec_in        = d;
      model_edge(v);
      cyc_n++;
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      model_reset();
      #1 check_outs();
      repeat (2) begin
         @(negedge clock);
         check_outs();
      end
      @(negedge clock);
      reset_n = 1'b1;
      model_edge(1'b0);
      cyc_n++;
   endtask

   initial begin
      vec_t v;
      #3 do_reset();
      v[0] = 32'h3f800000;
      v[1] = 32'h40000000;
      v[2] = 32'h40400000;
      v[3] = 32'h40800000;
      step(1, 0, v);
      repeat (6) step(0, 0, '0);
      for (int i = 0; i < W; i++) step(1, i == 0, rvec());
      repeat (12) step(0, 0, '0);
      repeat (3) step(1, 0, rvec());
      step(1, 1, rvec());
      repeat (7) step(1, 1, rvec());
      repeat (10) step(0, 0, '0);
      step(1, 1, rvec());
      step(1, 1, rvec());
      step(0, 0, '0);
      step(1, 0, rvec());
      repeat (12) step(0, 0, '0);
      for (int i = 0; i < W; i++) step(1, 1, rvec());
      @(negedge clock);
      check_outs();
      chk("progress_before_reset", 128'(weight_progress), 128'(3));
      #2 do_reset();
      for (int i = 0; i < W; i++) step(1, 1, rvec());
      repeat (12) step(0, 0, '0);
      repeat (400) step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, rvec());
      repeat (12) step(0, 0, '0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
